// File: rtl/slink_sync_fifo_if.sv
// Handshake, status and threshold bundle for slink_sync_fifo.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface slink_sync_fifo_if #(
  parameter int DATA_SIZE = 40,
  parameter int DEPTH     = 16
);
  localparam int CNT_SIZE = $clog2(DEPTH + 1);

  logic                 winc;
  logic [DATA_SIZE-1:0] wdata;
  logic                 rinc;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rvalid;
  logic                 wfull;
  logic                 rempty;
  logic [CNT_SIZE-1:0]  level;
  logic [CNT_SIZE-1:0]  swi_almost_full;
  logic [CNT_SIZE-1:0]  swi_almost_empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 half_full;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_errors;

  modport slave (
    input  winc, wdata, rinc, swi_almost_full, swi_almost_empty, clr_errors,
    output rdata, rvalid, wfull, rempty, level, almost_full, almost_empty,
           half_full, overflow, underflow
  );

  modport master (
    output winc, wdata, rinc, swi_almost_full, swi_almost_empty, clr_errors,
    input  rdata, rvalid, wfull, rempty, level, almost_full, almost_empty,
           half_full, overflow, underflow
  );
endinterface

// File: rtl/slink_sync_fifo.sv
// Single-clock FIFO of arbitrary depth with FWFT or registered read,
// exact occupancy, runtime almost-full/almost-empty thresholds and sticky error flags.
module slink_sync_fifo #(
  parameter int DATA_SIZE = 40,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 1
) (
  input  logic             clk,
  input  logic             reset,
  slink_sync_fifo_if.slave bus
);
  localparam int CNT_SIZE = $clog2(DEPTH + 1);
  localparam int PTR_SIZE = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_SIZE-1:0] PTR_LAST  = PTR_SIZE'(DEPTH - 1);
  localparam logic [CNT_SIZE:0]   DEPTH_EXT = (CNT_SIZE + 1)'(DEPTH);

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1.
  function automatic logic [PTR_SIZE-1:0] ptr_inc(input logic [PTR_SIZE-1:0] ptr);
    logic [PTR_SIZE-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_SIZE{1'b0}};
    end else begin
      nxt = ptr + PTR_SIZE'(1);
    end
    return nxt;
  endfunction

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [PTR_SIZE-1:0]  wptr_r;
  logic [PTR_SIZE-1:0]  rptr_r;
  logic [CNT_SIZE-1:0]  level_r;
  logic                 wfull_r;
  logic                 rempty_r;
  logic                 almost_full_r;
  logic                 almost_empty_r;
  logic                 half_full_r;
  logic                 overflow_r;
  logic                 underflow_r;

  logic                 wacc_s;
  logic                 racc_s;
  logic [CNT_SIZE:0]    level_next_s;
  logic [CNT_SIZE+1:0]  level_dbl_s;
  logic [DATA_SIZE-1:0] rdata_s;
  logic                 rvalid_s;

  // Acceptance is gated only by registered flags, never by the opposite request.
  assign wacc_s = bus.winc & ~wfull_r;
  assign racc_s = bus.rinc & ~rempty_r;

  // Next occupancy, one bit wider than level so the +1/-1 cannot wrap.
  always_comb begin
    level_next_s = {1'b0, level_r};
    if (wacc_s && !racc_s) begin
      level_next_s = {1'b0, level_r} + (CNT_SIZE + 1)'(1);
    end else if (racc_s && !wacc_s) begin
      level_next_s = {1'b0, level_r} - (CNT_SIZE + 1)'(1);
    end else begin
      level_next_s = {1'b0, level_r};
    end
    level_dbl_s = {level_next_s, 1'b0};
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wacc_s) begin
      mem_r[wptr_r] <= bus.wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= {PTR_SIZE{1'b0}};
      rptr_r  <= {PTR_SIZE{1'b0}};
      level_r <= {CNT_SIZE{1'b0}};
    end else begin
      if (wacc_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (racc_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      level_r <= level_next_s[CNT_SIZE-1:0];
    end
  end

  // Status flags derived from level_next so they line up with level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wfull_r        <= 1'b0;
      rempty_r       <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      half_full_r    <= 1'b0;
    end else begin
      wfull_r        <= (level_next_s == DEPTH_EXT);
      rempty_r       <= (level_next_s == {(CNT_SIZE + 1){1'b0}});
      almost_full_r  <= (level_next_s >= {1'b0, bus.swi_almost_full});
      almost_empty_r <= (level_next_s <= {1'b0, bus.swi_almost_empty});
      half_full_r    <= (level_dbl_s >= {1'b0, DEPTH_EXT});
    end
  end

  // Sticky errors: a new event in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.winc && wfull_r) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_errors) begin
        overflow_r <= 1'b0;
      end
      if (bus.rinc && rempty_r) begin
        underflow_r <= 1'b1;
      end else if (bus.clr_errors) begin
        underflow_r <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata_s  = mem_r[rptr_r];
      assign rvalid_s = ~rempty_r;
    end else begin : g_reg
      logic [DATA_SIZE-1:0] rdata_r;
      logic                 rvalid_r;

      // Registered read port: data lands the cycle after an accepted read.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_r  <= {DATA_SIZE{1'b0}};
          rvalid_r <= 1'b0;
        end else begin
          if (racc_s) begin
            rdata_r <= mem_r[rptr_r];
          end
          rvalid_r <= racc_s;
        end
      end

      assign rdata_s  = rdata_r;
      assign rvalid_s = rvalid_r;
    end
  endgenerate

  assign bus.rdata        = rdata_s;
  assign bus.rvalid       = rvalid_s;
  assign bus.wfull        = wfull_r;
  assign bus.rempty       = rempty_r;
  assign bus.level        = level_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.half_full    = half_full_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_slink_sync_fifo.sv
// Directed bench for slink_sync_fifo: one FWFT instance and one registered-read instance,
// both DEPTH=6 and DATA_SIZE=8.
module tb_slink_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  slink_sync_fifo_if #(.DATA_SIZE(DW), .DEPTH(DEPTH)) bus_a ();
  slink_sync_fifo_if #(.DATA_SIZE(DW), .DEPTH(DEPTH)) bus_b ();

  slink_sync_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .FWFT(1)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  slink_sync_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .FWFT(0)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] d);
    bus_a.winc  = 1'b1;
    bus_a.wdata = d;
    tick();
    bus_a.winc  = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [7:0] exp_d);
    check(tag, 32'(bus_a.rdata), 32'(exp_d));
    bus_a.rinc = 1'b1;
    tick();
    bus_a.rinc = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_level"}, 32'(bus_a.level), 32'd0);
    check({tag, "_rempty"}, 32'(bus_a.rempty), 32'd1);
    check({tag, "_wfull"}, 32'(bus_a.wfull), 32'd0);
    check({tag, "_afull"}, 32'(bus_a.almost_full), 32'd0);
    check({tag, "_aempty"}, 32'(bus_a.almost_empty), 32'd1);
    check({tag, "_half"}, 32'(bus_a.half_full), 32'd0);
    check({tag, "_ovf"}, 32'(bus_a.overflow), 32'd0);
    check({tag, "_unf"}, 32'(bus_a.underflow), 32'd0);
    check({tag, "_rvalid"}, 32'(bus_a.rvalid), 32'd0);
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.winc = 1'b0; bus_a.rinc = 1'b0; bus_a.wdata = 8'h00; bus_a.clr_errors = 1'b0;
    bus_a.swi_almost_full = 3'd4; bus_a.swi_almost_empty = 3'd1;
    bus_b.winc = 1'b0; bus_b.rinc = 1'b0; bus_b.wdata = 8'h00; bus_b.clr_errors = 1'b0;
    bus_b.swi_almost_full = 3'd0; bus_b.swi_almost_empty = 3'd0;
    tick();
    tick();
    check_reset_a("rst");
    check("rst_b_rdata", 32'(bus_b.rdata), 32'd0);
    check("rst_b_rvalid", 32'(bus_b.rvalid), 32'd0);
    check("rst_b_afull", 32'(bus_b.almost_full), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick();
    // Threshold 0 on instance B: almost_full rises on the first edge after release.
    check("b_afull_thr0", 32'(bus_b.almost_full), 32'd1);

    // Fill A with 0x11..0x16 and track every flag.
    for (int i = 1; i <= DEPTH; i++) begin
      write_a(8'(8'h10 + i));
      check("fill_level", 32'(bus_a.level), 32'(i));
      check("fill_wfull", 32'(bus_a.wfull), 32'(i == DEPTH));
      check("fill_afull", 32'(bus_a.almost_full), 32'(i >= 4));
      check("fill_half", 32'(bus_a.half_full), 32'(i >= 3));
      check("fill_aempty", 32'(bus_a.almost_empty), 32'(i <= 1));
      check("fill_rempty", 32'(bus_a.rempty), 32'd0);
    end
    // Drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      read_a("drain_data", 8'(8'h10 + i));
      check("drain_level", 32'(bus_a.level), 32'(DEPTH - i));
      check("drain_aempty", 32'(bus_a.almost_empty), 32'((DEPTH - i) <= 1));
    end
    check("drain_rempty", 32'(bus_a.rempty), 32'd1);
    check("drain_rvalid", 32'(bus_a.rvalid), 32'd0);

    // Underflow: sticky, and a set event beats a same-cycle clear.
    bus_a.rinc = 1'b1;
    tick();
    check("unf_set", 32'(bus_a.underflow), 32'd1);
    check("unf_level", 32'(bus_a.level), 32'd0);
    bus_a.clr_errors = 1'b1;
    tick();
    check("unf_set_wins", 32'(bus_a.underflow), 32'd1);
    bus_a.rinc = 1'b0;
    tick();
    check("unf_clr", 32'(bus_a.underflow), 32'd0);
    bus_a.clr_errors = 1'b0;

    // Pointer wrap: 4 in/out, then 5 words straddling index 5 -> 0.
    for (int i = 0; i < 4; i++) write_a(8'(8'h21 + i));
    for (int i = 0; i < 4; i++) read_a("wrap_pre", 8'(8'h21 + i));
    for (int i = 0; i < 5; i++) write_a(8'(8'hA0 + i));
    check("wrap_level", 32'(bus_a.level), 32'd5);
    for (int i = 0; i < 5; i++) read_a("wrap_data", 8'(8'hA0 + i));
    check("wrap_empty", 32'(bus_a.rempty), 32'd1);

    // Full with simultaneous write and read: read wins, write dropped.
    for (int i = 0; i < DEPTH; i++) write_a(8'(8'h31 + i));
    check("full_wfull", 32'(bus_a.wfull), 32'd1);
    bus_a.winc = 1'b1; bus_a.wdata = 8'h99; bus_a.rinc = 1'b1;
    tick();
    bus_a.winc = 1'b0; bus_a.rinc = 1'b0;
    check("full_rw_level", 32'(bus_a.level), 32'd5);
    check("full_rw_ovf", 32'(bus_a.overflow), 32'd1);
    check("full_rw_wfull", 32'(bus_a.wfull), 32'd0);
    check("full_rw_head", 32'(bus_a.rdata), 32'h32);
    bus_a.clr_errors = 1'b1;
    tick();
    bus_a.clr_errors = 1'b0;
    check("ovf_clr", 32'(bus_a.overflow), 32'd0);
    read_a("tail_data", 8'h32);
    read_a("tail_data", 8'h33);
    check("mid_level", 32'(bus_a.level), 32'd3);
    check("mid_half", 32'(bus_a.half_full), 32'd1);

    // Asynchronous reset mid-operation, checked before any clock edge.
    reset_a = 1'b1;
    #1;
    check_reset_a("async_rst");
    tick();
    reset_a = 1'b0;

    // Registered read mode on instance B.
    bus_b.winc = 1'b1; bus_b.wdata = 8'h5A;
    tick();
    bus_b.winc = 1'b0;
    check("b_level_w", 32'(bus_b.level), 32'd1);
    check("b_rvalid_idle", 32'(bus_b.rvalid), 32'd0);
    bus_b.rinc = 1'b1;
    tick();
    bus_b.rinc = 1'b0;
    check("b_rvalid_pulse", 32'(bus_b.rvalid), 32'd1);
    check("b_rdata", 32'(bus_b.rdata), 32'h5A);
    check("b_level_r", 32'(bus_b.level), 32'd0);
    tick();
    check("b_rvalid_end", 32'(bus_b.rvalid), 32'd0);
    check("b_rdata_hold", 32'(bus_b.rdata), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/slink_sync_fifo.md
# slink_sync_fifo

Single-clock, parametrised FIFO for S-Link datapaths where producer and consumer share a clock, e.g. packet staging and credit buffering. It generalises the team's dual-clock FIFO: any depth (not only powers of two), a selectable read mode (first-word fall-through or registered), an exact occupancy count, runtime almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. No synchronisers; all state is in one clock domain.

## Interface
- DATA_SIZE, 40, width of a data word
- DEPTH, 16, number of entries; any integer >= 2
- FWFT, 1, 1 = first-word fall-through (rdata shows head combinationally); 0 = registered read, data one cycle after accepted rinc
- CNT_SIZE (localparam) = $clog2(DEPTH+1), width of occupancy/threshold values
- clk  input  1  single clock, all logic on posedge
- reset  input  1  asynchronous, active-high reset
- winc  input  1  write request
- wdata  input  DATA_SIZE  write data
- rinc  input  1  read request
- rdata  output  DATA_SIZE  read data
- rvalid  output  1  FWFT=1: equals ~rempty; FWFT=0: one-cycle pulse, rdata updated this cycle
- wfull  output  1  level == DEPTH
- rempty  output  1  level == 0
- level  output  CNT_SIZE  current occupancy, 0..DEPTH
- swi_almost_full  input  CNT_SIZE  almost_full threshold
- swi_almost_empty  input  CNT_SIZE  almost_empty threshold
- almost_full  output  1  level >= swi_almost_full
- almost_empty  output  1  level <= swi_almost_empty
- half_full  output  1  2*level >= DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty
- clr_errors  input  1  synchronous clear of overflow/underflow

## Operation
- Write accepted (wacc) = winc & ~wfull; read accepted (racc) = rinc & ~rempty. Full/empty gating uses registered flags, never rinc/winc of the same cycle: write while full is rejected even if a read is accepted that cycle.
- On wacc: mem[wptr] <= wdata; wptr advances. On racc: rptr advances. Pointers range 0..DEPTH-1 and wrap DEPTH-1 -> 0 explicitly (no power-of-two masking).
- level_next = level + wacc - racc, computed at CNT_SIZE+1 bits; never exceeds DEPTH nor falls below 0.
- wfull, rempty, almost_full, almost_empty, half_full are registered, computed from level_next, so they always agree with level in the same cycle.
- Simultaneous wacc and racc: level unchanged, both pointers advance; when level==1 in FWFT mode head moves to the new word next cycle.
- FWFT=1: rdata = mem[rptr] combinationally; undefined while rempty (bench must not check).
- FWFT=0: rdata register loaded with mem[rptr] on racc, holds otherwise; rvalid = racc delayed one cycle.
- overflow set on winc & wfull; underflow set on rinc & rempty; cleared by clr_errors; a set event in the same cycle as clr_errors wins. Rejected accesses change no other state.
- Threshold inputs are sampled every cycle; a change takes effect on the flag one cycle later.
- Memory array is not reset.

## Timing
- Reset values: level 0, rempty 1, wfull 0, almost_full 0, almost_empty 1, half_full 0, overflow 0, underflow 0, rvalid 0, rdata register 0, pointers 0.
- After reset release, flags follow level_next from the first edge (e.g. swi_almost_full = 0 gives almost_full = 1 one cycle after release).
- Write at edge N: level, rempty, and FWFT rdata reflect it in cycle N+1 (one-cycle write-to-read latency).
- Read accepted at edge N: FWFT=0 rdata/rvalid valid in cycle N+1; level and flags update in cycle N+1.
- Reset asserted mid-operation: all registers return to reset values asynchronously; contents are discarded.

## Test plan
- DEPTH=6, DATA_SIZE=8, FWFT=1: write 0x11..0x16 on consecutive cycles -> level 1..6, wfull=1 after 6th; read 6 -> data 0x11..0x16 in order, rempty=1, level=0.
- Pointer wrap, DEPTH=6: 4 writes, 4 reads, then 5 writes 0xA0..0xA4 -> reads return 0xA0..0xA4 across index 5 -> 0 boundary.
- Full with winc&rinc same cycle at level 6 -> read accepted, write dropped, level 5, overflow=1; clr_errors -> overflow=0 next cycle.
- Empty with rinc -> underflow=1, level stays 0; rinc and clr_errors same cycle -> underflow stays 1.
- FWFT=0: write 0x5A, rinc next cycle -> rvalid pulses one cycle later with rdata=0x5A, then rdata holds 0x5A.
- Thresholds swi_almost_full=4, swi_almost_empty=1, DEPTH=6: fill to 4 -> almost_full=1, half_full=1 from level 3; drain to 1 -> almost_empty=1; assert reset at level 3 -> all outputs at reset values immediately.
